// File: rtl/des_round_ctrl.sv
// Iterative DES Feistel round controller: holds the L/R halves, runs one round per
// cycle against an external combinational f-path and presents R16||L16 when finished.
module des_round_ctrl #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [64:1] block_in,
    input  logic [32:1] f_out,
    output logic [32:1] r_out,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic [64:1] block_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(NROUNDS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [32:1] r_l;
    logic [32:1] r_r;
    logic [3:0]  r_cnt;
    logic        r_dec;
    logic [64:1] r_block_out;
    logic        w_last;
    logic [32:1] w_new_r;

    assign w_last  = (r_cnt == LAST_CNT);
    assign w_new_r = r_l ^ f_out;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: the default is assigned before the case so no path can leave it unassigned and infer a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_ROUND;
            ST_ROUND: if (w_last) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: block_out is reset along with the halves so an aborted block leaves no residue visible.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_l         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_dec       <= 1'b0;
            r_block_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_l   <= block_in[64:33];
                        r_r   <= block_in[32:1];
                        r_dec <= decrypt;
                        r_cnt <= '0;
                    end
                end
                ST_ROUND: begin
                    r_l <= r_r;
                    r_r <= w_new_r;
                    if (w_last) begin
                        // Completing round: the halves leave swapped, R16 in the upper word.
                        r_block_out <= {w_new_r, r_r};
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == ST_ROUND);
    assign done      = (r_state == ST_DONE);
    assign r_out     = r_r;
    assign block_out = r_block_out;
    // Decrypt walks the key schedule backwards; the f-path sees subkey 0 outside ROUND.
    assign round_idx = !busy ? 4'd0 : (r_dec ? (LAST_CNT - r_cnt) : r_cnt);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: swap/latency, round index order, full DES
// integration through a bench-side f-path, start abuse and mid-block reset.
module tb_des_round_ctrl;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        decrypt;
    logic [63:0] block_in;
    logic [31:0] f_out;
    logic [31:0] r_out;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic [63:0] block_out;

    logic [1:0]  f_mode;
    logic [47:0] subkey [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    localparam int IP_OFF  = 0;
    localparam int FP_OFF  = 64;
    localparam int P_OFF   = 128;
    localparam int PC1_OFF = 160;
    localparam int PC2_OFF = 216;

    // IP, FP, P, PC1, PC2 concatenated; entries are 1-based positions counted from the MSB.
    byte perm_t [264] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7,
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25,
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25,
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4,
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32
    };

    byte sbox [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
    };

    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_round_ctrl #(.NROUNDS(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .decrypt   (decrypt),
        .block_in  (block_in),
        .f_out     (f_out),
        .r_out     (r_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .block_out (block_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] permute(input logic [63:0] x, input int n_in, input int off, input int n_out);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < n_out; i++) y[n_out-1-i] = x[n_in - int'(perm_t[off+i])];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  six;
        int          pos;
        int          row;
        int          col;
        e = '0;
        s = '0;
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 6; j++) begin
                pos = ((4*g + j + 31) % 32) + 1;
                e[47-6*g-j] = r[32-pos];
            end
        end
        e = e ^ k;
        for (int g = 0; g < 8; g++) begin
            six = e[47-6*g -: 6];
            row = int'({six[5], six[0]});
            col = int'(six[4:1]);
            s[31-4*g -: 4] = 4'(sbox[g*64 + row*16 + col]);
        end
        return 32'(permute({32'h0, s}, 32, P_OFF, 32));
    endfunction

    // Reference Feistel with the debug f-path f = R ^ round index.
    function automatic logic [63:0] idx_model(input logic [63:0] din, input logic dec);
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] nr;
        logic [3:0]  idx;
        l = din[63:32];
        r = din[31:0];
        for (int k = 0; k < 16; k++) begin
            idx = dec ? 4'(15 - k) : 4'(k);
            nr  = l ^ (r ^ {28'h0, idx});
            l   = r;
            r   = nr;
        end
        return {r, l};
    endfunction

    always_comb begin
        f_out = '0;
        case (f_mode)
            2'd1:    f_out = r_out ^ {28'h0, round_idx};
            2'd2:    f_out = des_f(r_out, subkey[round_idx]);
            default: f_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r_out"}, 64'(r_out), 64'h0);
        check({tag, "_idx"}, 64'(round_idx), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_block_out"}, block_out, 64'h0);
    endtask

    // Starts a block from IDLE and follows it to the cycle after DONE.
    task automatic run_block(input logic [63:0] din, input logic dec, output logic [63:0] dout);
        block_in = din;
        decrypt  = dec;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        decrypt  = ~dec;
        for (int k = 0; k < 16; k++) begin
            check("busy_round", 64'(busy), 64'h1);
            check("round_idx", 64'(round_idx), dec ? 64'(15 - k) : 64'(k));
            tick();
        end
        check("done_pulse", 64'(done), 64'h1);
        check("busy_after", 64'(busy), 64'h0);
        dout = block_out;
        tick();
        check("done_once", 64'(done), 64'h0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] key;
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        int          dpos [4];
        int          nd;

        key = 64'h1334_5779_9BBC_DFF1;
        cd  = 56'(permute(key, 64, PC1_OFF, 56));
        c   = cd[55:28];
        d   = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < shifts[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            subkey[i] = 48'(permute({8'h0, c, d}, 56, PC2_OFF, 48));
        end

        // Reset with random inputs, then idle with no start.
        f_mode = 2'd0;
        n_rst  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom);
            decrypt  = 1'($urandom);
            block_in = {$urandom, $urandom};
            tick();
            check_zero("reset");
        end
        start = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        tick();
        tick();
        check_zero("idle_no_start");

        // Pure swap: f = 0.
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, res);
        check("swap_block_out", res, 64'h89AB_CDEF_0123_4567);

        // Round index ordering through f = R ^ idx.
        f_mode = 2'd1;
        run_block(64'hFFFF_FFFF_0000_0000, 1'b0, res);
        check("idx_enc_block", res, idx_model(64'hFFFF_FFFF_0000_0000, 1'b0));
        run_block(64'hFFFF_FFFF_0000_0000, 1'b1, res);
        check("idx_dec_block", res, idx_model(64'hFFFF_FFFF_0000_0000, 1'b1));

        // Full DES through the bench f-path and key schedule.
        f_mode = 2'd2;
        run_block(permute(64'h0123_4567_89AB_CDEF, 64, IP_OFF, 64), 1'b0, res);
        check("des_encrypt", permute(res, 64, FP_OFF, 64), 64'h85E8_1354_0F0A_B405);
        run_block(permute(64'h85E8_1354_0F0A_B405, 64, IP_OFF, 64), 1'b1, res);
        check("des_decrypt", permute(res, 64, FP_OFF, 64), 64'h0123_4567_89AB_CDEF);

        // start held high: completions every 18 cycles.
        f_mode   = 2'd0;
        block_in = 64'h0123_4567_89AB_CDEF;
        decrypt  = 1'b0;
        start    = 1'b1;
        nd       = 0;
        for (int cyc = 1; cyc <= 56; cyc++) begin
            tick();
            if (done) begin
                if (nd < 4) dpos[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("held_done_count", 64'(nd), 64'd3);
        check("held_done_1", 64'(dpos[0]), 64'd17);
        check("held_done_2", 64'(dpos[1]), 64'd35);
        check("held_done_3", 64'(dpos[2]), 64'd53);
        check("held_block_out", block_out, 64'h89AB_CDEF_0123_4567);
        repeat (20) tick();

        // Start pulses in ROUND and DONE are ignored.
        block_in = 64'h1111_1111_2222_2222;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        block_in = 64'h3333_3333_4444_4444;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("abuse_hold_out", block_out, 64'h89AB_CDEF_0123_4567);
        repeat (12) tick();
        check("abuse_done", 64'(done), 64'h1);
        check("abuse_block_out", block_out, 64'h2222_2222_1111_1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abuse_done_start_busy", 64'(busy), 64'h0);
        tick();
        check("abuse_idle_busy", 64'(busy), 64'h0);
        check("abuse_idle_out", block_out, 64'h2222_2222_1111_1111);

        // Reset during round 7, then a clean block.
        f_mode   = 2'd1;
        block_in = 64'hDEAD_BEEF_0BAD_F00D;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("pre_reset_busy", 64'(busy), 64'h1);
        #2;
        n_rst = 1'b0;
        #1;
        check_zero("mid_reset");
        tick();
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check_zero("post_reset_idle");
        run_block(64'hCAFE_F00D_1234_5678, 1'b0, res);
        check("post_reset_block", res, idx_model(64'hCAFE_F00D_1234_5678, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES Feistel round controller. It sits directly downstream of the P-permutation stage and holds the L/R half-block registers. Each cycle it XORs the permuted f-function result into L and swaps the halves, for 16 rounds. It also drives the R half and the subkey round index back into the combinational f-path (expansion, key XOR, S-boxes, P-perm), and delivers the pre-output block R16‖L16 to the final-permutation stage.

## Interface
Parameters:
- NROUNDS, 16, number of Feistel rounds; fixed at 16 for DES, exposed only for reduced-round debug builds.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  request to begin a block; sampled only in IDLE.
- decrypt  in  1  0 = encrypt, 1 = decrypt; latched with start.
- block_in  in  [64:1]  block after initial permutation; L0 = [64:33], R0 = [32:1].
- f_out  in  [32:1]  output of the P-permutation stage for the current round; combinational from r_out and the current subkey.
- r_out  out  [32:1]  current R register, feeding the expansion stage.
- round_idx  out  [3:0]  subkey select for the key schedule.
- busy  out  1  high while in ROUND.
- done  out  1  one-cycle pulse when block_out becomes valid.
- block_out  out  [64:1]  pre-output R16‖L16, with R16 in [64:33], for the final permutation.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - If start = 1: load L ← block_in[64:33], R ← block_in[32:1], dec_q ← decrypt, cnt ← 0, then go to ROUND.
  - Otherwise hold.
- ROUND, every cycle:
  - L ← R
  - R ← L ^ f_out
  - cnt ← cnt + 1
  - When cnt = NROUNDS−1 at the edge, the last round completes: block_out ← {L ^ f_out, R}, i.e. the swapped halves, then go to DONE.
- DONE: done = 1 for exactly this cycle; go to IDLE unconditionally.
- round_idx:
  - Encrypt: equals cnt.
  - Decrypt: equals NROUNDS−1−cnt.
  - Forced to 0 outside ROUND.
- r_out always equals the R register; the f-path must settle within one cycle.
- start is ignored in ROUND and DONE. No queueing and no abort; a request is accepted only from IDLE.
- block_out changes only on a completing round. It holds its value through IDLE until the next completion.
- cnt is 4 bits and never wraps inside a block; it is cleared on load.

## Timing
- Reset (n_rst = 0, any time, including mid-block):
  - state = IDLE.
  - L, R, cnt, dec_q = 0.
  - block_out = 0, r_out = 0, round_idx = 0, busy = 0, done = 0.
  - The in-flight block is discarded.
- Latency:
  - start is sampled at edge E0.
  - busy is high in the cycles after E0 … E15.
  - Round k (k = 1..16) is performed at edge Ek.
  - done is high in the cycle after E16, and block_out is valid from that cycle.
  - Throughput: one block per 18 cycles if start is held high (the IDLE cycle is mandatory).
- The cycle in which round_idx = i is the cycle whose closing edge consumes subkey i.
- start asserted in the DONE cycle is ignored. It is accepted on the following IDLE cycle if still high.
- decrypt changing mid-block has no effect.

## Test plan
- Reset: hold n_rst low with random inputs → all outputs 0. Release n_rst, no start → outputs stay 0 and state stays IDLE.
- Swap check with f_out tied to 0 and block_in = 0123456789ABCDEF:
  - Pulse start → busy high for exactly 16 cycles.
  - done pulses once, 17 cycles after the start edge.
  - block_out = 89ABCDEF01234567.
- Round index and f wiring with f_out driven as r_out ^ {28'h0, round_idx}:
  - Encrypt: round_idx runs 0..15.
  - Decrypt: round_idx runs 15..0.
  - Compare block_out against the bench model for block_in = FFFFFFFF00000000.
- Integration with the full f-path, P-perm and key schedule, key 133457799BBCDFF1:
  - Encrypt plaintext 0123456789ABCDEF → ciphertext 85E813540F0AB405 after FP.
  - Decrypt of that ciphertext returns the plaintext.
- Start abuse:
  - start held high continuously → blocks complete every 18 cycles.
  - A start pulse during ROUND or DONE → no restart; block_out is unchanged until the current block completes.
- Reset mid-op: drop n_rst at round 7 → immediate zeros. A new start after release completes a correct block with no residue from the aborted one.
